// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_t  : arbiter FSM encoding (IDLE, GRANT)
//   grant_width  : width of a requester index for a given requester count
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // A single requester still needs a 1-bit index so ports never collapse to zero width.
    function automatic int grant_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
//   req        : request vector, one bit per requester
//   last_grant : index granted most recently; search starts at last_grant+1
//   pick       : first requesting index found searching upward with wrap
//   any        : at least one request bit is set
module rr_priority_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     pick,
    output logic               any
);

    logic found;

    // Offset k walks the ring starting just after last_grant; the first hit wins.
    // The inner loop keeps every bit-select on a constant index.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        any   = |req;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
                    pick  = IDW'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant is held for a whole burst (until req_last or MAX_BURST beats).
//   clk, rst_n          : clock; synchronous active-high reset (despite the name)
//   req_valid/last/data : per-requester beat stream, data packed at [i*BITLEN +: BITLEN]
//   req_ready           : beat accept, only ever set for the granted requester
//   fifo_full           : FIFO back-pressure
//   fifo_wr_en/fifo_din : FIFO write port, combinational from the granted requester
//   grant_valid/grant_id: current grant
//   burst_trunc         : one-cycle pulse after a MAX_BURST forced release
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int BITLEN    = 64,
    parameter  int MAX_BURST = 16,
    localparam int IDW       = grant_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*BITLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [BITLEN-1:0]         fifo_din,
    output logic                      grant_valid,
    output logic [IDW-1:0]            grant_id,
    output logic                      burst_trunc
);

    localparam int CNTW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t         state;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     pick;
    logic               pick_any;
    logic [CNTW-1:0]    beat_cnt;
    logic [NUM_REQ-1:0] sel_oh;
    logic               sel_valid;
    logic               sel_last;
    logic [BITLEN-1:0]  sel_data;
    logic               accept;
    logic               at_max;
    logic               release_burst;

    rr_priority_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any        (pick_any)
    );

    // Select the granted requester's stream; constant-index selects only.
    always_comb begin
        sel_oh    = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*BITLEN +: BITLEN];
            end
        end
    end

    assign accept        = (state == GRANT) & sel_valid & ~fifo_full;
    assign at_max        = (beat_cnt == CNTW'(MAX_BURST - 1));
    assign release_burst = accept & (sel_last | at_max);

    // Ready depends only on the grant and fifo_full, never on the producer's valid.
    assign req_ready  = ((state == GRANT) && !fifo_full) ? sel_oh : '0;
    assign fifo_wr_en = accept;
    assign fifo_din   = sel_data;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            burst_trunc <= 1'b0;
            beat_cnt    <= '0;
            // Pointing at the top index makes requester 0 the first candidate.
            last_grant  <= IDW'(NUM_REQ - 1);
        end else begin
            burst_trunc <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id    <= pick;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_burst) begin
                        state       <= IDLE;
                        last_grant  <= grant_id;
                        beat_cnt    <= '0;
                        grant_valid <= 1'b0;
                        // A real last beat on the final counted beat is not a truncation.
                        burst_trunc <= ~sel_last;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
